// File: rtl/coram_stream_pkg.sv
// Shared constants and sizing helpers for the CoRAM stream reader/writer blocks.
package coram_stream_pkg;

  localparam int unsigned DefaultBufAddrLen = 1;
  localparam int unsigned DefaultDepth      = 2 ** DefaultBufAddrLen;

  // Occupancy must represent 0..Depth inclusive, hence one extra bit over the pointers.
  function automatic int unsigned occ_width(int unsigned addr_len);
    return addr_len + 1;
  endfunction

endpackage

// File: rtl/coram_instream_reader_if.sv
// Input-stream (DEQ/Q/EMPTY) and output valid/ready signals of the stream reader.
interface coram_instream_reader_if #(
  parameter int unsigned DataWidth = 32
);
  logic [DataWidth-1:0] in_q;
  logic                 in_deq;
  logic                 in_empty;
  logic                 in_alm_empty;
  logic [DataWidth-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_q, in_empty, in_alm_empty, out_ready,
    input  in_deq, out_data, out_valid
  );

  modport slave (
    input  in_q, in_empty, in_alm_empty, out_ready,
    output in_deq, out_data, out_valid
  );
endinterface

// File: rtl/coram_prefetch_fifo.sv
// Register FIFO of 2**AddrLen entries; occupancy and head are visible with no flag latency.
module coram_prefetch_fifo
  import coram_stream_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrLen   = DefaultBufAddrLen,
  localparam int unsigned Depth    = 2 ** AddrLen,
  localparam int unsigned OccW     = occ_width(AddrLen)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic                 pop_i,
  output logic [OccW-1:0]      occ_o,
  output logic [DataWidth-1:0] head_o
);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [AddrLen-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AddrLen-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0]      occ_q, occ_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_i, pop_i})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // Storage is cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push_i) mem_q[wr_ptr_q] <= wdata_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign occ_o  = occ_q;
  assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/coram_instream_reader.sv
// Turns the CoRAM input stream DEQ/Q interface into a valid/ready stream with a prefetch buffer.
module coram_instream_reader
  import coram_stream_pkg::*;
#(
  parameter int unsigned CoramDataWidth = 32,
  parameter int unsigned BufAddrLen     = DefaultBufAddrLen,
  parameter int unsigned CntWidth       = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  coram_instream_reader_if.slave    strm,
  output logic [CntWidth-1:0]       word_count_o
);

  localparam int unsigned Depth = 2 ** BufAddrLen;
  localparam int unsigned OccW  = occ_width(BufAddrLen);
  localparam int unsigned CrW   = OccW + 1;

  logic                      pend_q, pend_d;
  logic [CntWidth-1:0]       cnt_q, cnt_d;
  logic [OccW-1:0]           occ;
  logic [CoramDataWidth-1:0] head;
  logic                      pop;
  logic                      deq;
  logic [CrW-1:0]            credit_used;

  coram_prefetch_fifo #(
    .DataWidth (CoramDataWidth),
    .AddrLen   (BufAddrLen)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (pend_q),
    .wdata_i (strm.in_q),
    .pop_i   (pop),
    .occ_o   (occ),
    .head_o  (head)
  );

  // Credit counts the word still in flight from the stream; the ALM_EMPTY term stops a second
  // DEQ while the first one's effect on the flags may not yet be visible.
  always_comb begin
    pop         = (occ != '0) && strm.out_ready;
    credit_used = {1'b0, occ} + CrW'(pend_q) - CrW'(pop);
    deq         = !rst_i && !strm.in_empty && (credit_used < CrW'(Depth))
                  && !(strm.in_alm_empty && pend_q);
    pend_d      = deq;
    cnt_d       = cnt_q + CntWidth'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign strm.in_deq    = deq;
  assign strm.out_valid = (occ != '0);
  assign strm.out_data  = head;
  assign word_count_o   = cnt_q;

endmodule
